wr_en_arbiter: RTL
==================

# wr_en_arbiter

Round-robin controller that shares a single write port (`enable`/`write`/address/data) between `N_REQ` requesters. It sequences every access as a one-cycle enable setup followed by a burst of write beats, so `write` is only ever high while `enable` is high. It sits between requesting agents and the shared register/memory write port.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 4: write address width.
- `DATA_W`, 8: write data width.
- `BURST_MAX`, 4: maximum write beats per grant (1..15).

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_REQ  per-requester access request, level.
- `req_addr`  in  N_REQ*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W].
- `req_data`  in  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
- `gnt`  out  N_REQ  one-hot grant, high for SETUP and WRITE.
- `ack`  out  N_REQ  one-hot beat accept, high in each write cycle of the granted requester.
- `enable`  out  1  shared port enable.
- `write`  out  1  shared port write strobe.
- `wr_addr`  out  ADDR_W  registered write address.
- `wr_data`  out  DATA_W  registered write data.

## Operation
- States: IDLE, SETUP, WRITE. All outputs registered.
- IDLE: `enable`=`write`=0, `gnt`=`ack`=0. If any `req` bit is set, pick winner w by round-robin, starting search at `ptr`+1 (mod N_REQ); update `ptr`=w; go SETUP.
- SETUP: `gnt`[w]=1, `enable`=1, `write`=0. At next edge: if `req`[w]=1, capture `req_addr`/`req_data` of w into `wr_addr`/`wr_data`, beat count=1, go WRITE; else abort to IDLE (no write, no ack).
- WRITE: `enable`=1, `write`=1, `ack`[w]=1, `gnt`[w]=1. At each edge: if `req`[w]=1 and count<BURST_MAX, capture next beat, count+1, stay; else go IDLE.
- Requester handshake: beat presented on `req_addr`/`req_data` is consumed at the edge that raises (or keeps) `write`; `ack` high means the next beat, if any, must be valid by the next edge; requester drops `req` in the cycle of its final `ack`.
- Burst limit: after BURST_MAX beats, grant is released even with `req`[w] high; w rejoins arbitration as lowest priority.
- Beat counter width: $clog2(BURST_MAX+1); never wraps.
- `wr_addr`/`wr_data` hold last value when `write`=0.
- Reset: state IDLE, `ptr`=N_REQ-1 (requester 0 highest priority), all outputs 0 including `wr_addr`/`wr_data`. Reset mid-burst takes effect at the next edge; the interrupted burst is dropped.

## Timing
- Request sampled in IDLE at edge t → `gnt`/`enable` high in cycle t+1 → first `write` in cycle t+2.
- Burst of k beats: `enable` high k+1 cycles, `write` high k cycles.
- Minimum gap between bursts: 1 IDLE cycle (enable low) + 1 SETUP cycle (write low).
- Simultaneous requests: single winner per IDLE cycle, others wait; worst-case wait for a held request ≤ (N_REQ-1)*(BURST_MAX+2) cycles.

## Configuration
- `WR_EN_ARBITER_ASSERT_EN` defined: concurrent assertions compiled in, clocked on `clk`, disabled iff `rst`: `write |-> enable`; `$onehot0(gnt)`; `enable |-> $onehot(gnt)`; `ack == (gnt & {N_REQ{write}})`; no more than BURST_MAX consecutive `write` cycles; `req[i]` held high → `gnt[i]` within (N_REQ-1)*(BURST_MAX+2)+1 cycles. Failures report via `$error`.
- Not defined: no assertion code; RTL behaviour identical.

## Test plan
- `rst`=1 for 2 cycles with `req`=4'b1111 → all outputs 0 during and one cycle after release; first grant goes to requester 0.
- `req`[2] high one beat, `req_addr`=4'h3, `req_data`=8'hA5, dropped on `ack` → cycle t+1 `gnt`=0100, `enable`=1, `write`=0; t+2 `write`=1, `ack`=0100, `wr_addr`=3, `wr_data`=A5; t+3 `enable`=`write`=0.
- `req`=4'b1111 held → grant order 0,1,2,3,0; each burst exactly 4 write cycles; 2 non-write cycles between bursts.
- `req`[1] alone, dropped during SETUP → `enable` falls next cycle, `write` and `ack` never high; next `req`=4'b0011 grants requester 0 is skipped? no: pointer=1, so requester 0 wins... search from 2 → requester 0 granted.
- `rst` pulsed in second WRITE beat of requester 3 → next cycle all outputs 0; with `req`=4'b1001 held, requester 0 granted first.
- With `WR_EN_ARBITER_ASSERT_EN` defined, run scenarios 2–5 → zero assertion failures.

Source files
------------

// File: rtl/wr_en_arbiter.sv
// Round-robin arbiter sharing one enable/write port between N_REQ requesters.
// Optional checks: define WR_EN_ARBITER_ASSERT_EN to compile in protocol assertions.
module wr_en_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    enable,
    output logic                    write,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data
);
    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [IDX_W-1:0]  win, win_nxt;
    logic [IDX_W-1:0]  pick, cand;
    logic              found;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt, ack_nxt;
    logic              enable_nxt, write_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic [N_REQ-1:0]  pick_oh, win_oh;

    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
        assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end

    assign pick_oh = N_REQ'(1) << pick;
    assign win_oh  = N_REQ'(1) << win;

    // Round-robin search starting just after the last winner
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        win_nxt    = win;
        cnt_nxt    = cnt;
        gnt_nxt    = '0;
        ack_nxt    = '0;
        enable_nxt = 1'b0;
        write_nxt  = 1'b0;
        addr_nxt   = wr_addr;
        data_nxt   = wr_data;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt  = SETUP;
                    ptr_nxt    = pick;
                    win_nxt    = pick;
                    cnt_nxt    = '0;
                    gnt_nxt    = pick_oh;
                    enable_nxt = 1'b1;
                end
            end
            SETUP: begin
                if (req[win]) begin
                    state_nxt  = WRITE;
                    cnt_nxt    = CNT_W'(1);
                    gnt_nxt    = win_oh;
                    ack_nxt    = win_oh;
                    enable_nxt = 1'b1;
                    write_nxt  = 1'b1;
                    addr_nxt   = addr_arr[win];
                    data_nxt   = data_arr[win];
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                if (req[win] && (cnt < CNT_W'(BURST_MAX))) begin
                    cnt_nxt    = cnt + CNT_W'(1);
                    gnt_nxt    = win_oh;
                    ack_nxt    = win_oh;
                    enable_nxt = 1'b1;
                    write_nxt  = 1'b1;
                    addr_nxt   = addr_arr[win];
                    data_nxt   = data_arr[win];
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= IDX_W'(N_REQ - 1);
            win     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            ack     <= '0;
            enable  <= 1'b0;
            write   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            cnt     <= cnt_nxt;
            gnt     <= gnt_nxt;
            ack     <= ack_nxt;
            enable  <= enable_nxt;
            write   <= write_nxt;
            wr_addr <= addr_nxt;
            wr_data <= data_nxt;
        end
    end

`ifdef WR_EN_ARBITER_ASSERT_EN
    localparam int unsigned WAIT_MAX = (N_REQ - 1) * (BURST_MAX + 2) + 1;

    int unsigned wr_run;
    int unsigned wait_cnt [N_REQ];

    // Run length of write cycles and per-requester starvation counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_run <= 0;
            for (int i = 0; i < N_REQ; i++) wait_cnt[i] <= 0;
        end else begin
            wr_run <= write ? wr_run + 1 : 0;
            for (int i = 0; i < N_REQ; i++)
                wait_cnt[i] <= (req[i] && !gnt[i]) ? wait_cnt[i] + 1 : 0;
        end
    end

    a_wr_en: assert property (@(posedge clk) disable iff (rst) write |-> enable)
        else $error("write without enable");
    a_gnt_oh0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("gnt not onehot0");
    a_en_gnt: assert property (@(posedge clk) disable iff (rst) enable |-> $onehot(gnt))
        else $error("enable without single grant");
    a_ack: assert property (@(posedge clk) disable iff (rst) ack == (gnt & {N_REQ{write}}))
        else $error("ack inconsistent with gnt/write");
    a_burst: assert property (@(posedge clk) disable iff (rst) write |-> (wr_run < BURST_MAX))
        else $error("write burst too long");
    for (genvar i = 0; i < N_REQ; i++) begin : g_fair
        a_fair: assert property (@(posedge clk) disable iff (rst) wait_cnt[i] < WAIT_MAX)
            else $error("requester %0d starved", i);
    end
`endif

endmodule
